distinct_value_tracker: RTL and testbench

Captures up to four distinct non-zero values from a byte-wide stream into four slots. It presents each slot as a registered value/valid pair. Repeated values are absorbed; a new value arriving while all slots are full evicts one entry. It sits after a sampled data source and provides a compact "set of recently seen codes" to downstream logic.

---
 rtl/distinct_value_tracker_pkg.sv | 22 ++
 rtl/dvt_repl_ctrl.sv | 90 +++++++++
 rtl/distinct_value_tracker.sv | 73 +++++++
 tb/tb_distinct_value_tracker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/distinct_value_tracker_pkg.sv
// distinct_value_tracker_pkg: shared types and helpers for the distinct value tracker.
// Optional feature macro: DVT_LRU_EN (least-recently-used replacement instead of FIFO).
package distinct_value_tracker_pkg;

    localparam int NUM_SLOTS = 4;

    typedef logic [1:0] slot_idx_t;
    typedef logic [1:0] age_t;

    // Index of the lowest set bit; returns 0 when no bit is set.
    function automatic slot_idx_t lowest_set(input logic [NUM_SLOTS-1:0] vec);
        slot_idx_t idx;
        idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = slot_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dvt_repl_ctrl.sv
// dvt_repl_ctrl: picks the slot to write on a miss, either the lowest free slot
// or a victim. Victim selection is a round-robin pointer by default, or
// least-recently-accessed slot (2-bit ages, 0 = newest) when DVT_LRU_EN is defined.
module dvt_repl_ctrl
    import distinct_value_tracker_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic [NUM_SLOTS-1:0] slot_valid,
    input  logic                 hit_en,
    input  slot_idx_t            hit_idx,
    input  logic                 miss_en,
    output slot_idx_t            write_idx
);

    logic      free_avail;
    slot_idx_t free_idx;
    slot_idx_t victim_idx;

    // Lowest invalid slot wins; eviction only happens once every slot is valid.
    always_comb begin
        free_avail = ~(&slot_valid);
        free_idx   = lowest_set(~slot_valid);
        write_idx  = free_avail ? free_idx : victim_idx;
    end

`ifdef DVT_LRU_EN

    age_t      ages     [NUM_SLOTS];
    age_t      ages_next[NUM_SLOTS];
    slot_idx_t access_idx;
    age_t      access_age;

    // Touched slot becomes newest; only slots newer than it age by one, so ages stay a permutation.
    always_comb begin
        access_idx = hit_en ? hit_idx : write_idx;
        access_age = ages[access_idx];
        for (int j = 0; j < NUM_SLOTS; j++) begin
            ages_next[j] = ages[j];
            if (slot_idx_t'(j) == access_idx) begin
                ages_next[j] = '0;
            end else if (ages[j] < access_age) begin
                ages_next[j] = ages[j] + age_t'(1);
            end
        end
    end

    // Victim is the oldest slot, the one whose age is 3.
    always_comb begin
        victim_idx = '0;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            if (ages[j] == age_t'(NUM_SLOTS - 1)) begin
                victim_idx = slot_idx_t'(j);
            end
        end
    end

    // Age registers restart at 0,1,2,3 and move on every hit or insert.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                ages[j] <= age_t'(j);
            end
        end else if (hit_en || miss_en) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                ages[j] <= ages_next[j];
            end
        end
    end

`else

    slot_idx_t fifo_ptr;
    logic      unused_hit;

    assign unused_hit = hit_en ^ (^hit_idx);
    assign victim_idx = fifo_ptr;

    // Round-robin pointer advances only on an eviction; the 2-bit add wraps 3 to 0.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            fifo_ptr <= '0;
        end else if (miss_en && !free_avail) begin
            fifo_ptr <= fifo_ptr + slot_idx_t'(1);
        end
    end

`endif

endmodule

// File: rtl/distinct_value_tracker.sv
// distinct_value_tracker: keeps up to four distinct non-zero byte codes seen on
// data_in, one per registered slot. Repeats are absorbed, a new code with all
// slots full evicts one entry. Replacement policy is FIFO unless DVT_LRU_EN is defined.
module distinct_value_tracker
    import distinct_value_tracker_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] out_0,
    output logic [DATA_W-1:0] out_1,
    output logic [DATA_W-1:0] out_2,
    output logic [DATA_W-1:0] out_3,
    output logic              out_valid_0,
    output logic              out_valid_1,
    output logic              out_valid_2,
    output logic              out_valid_3
);

    logic [DATA_W-1:0]    slot_val [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_vld;
    logic [NUM_SLOTS-1:0] match;
    logic                 hit_en;
    logic                 miss_en;
    slot_idx_t            hit_idx;
    slot_idx_t            write_idx;

    // Compare the sample against registered slots only; stored codes are distinct so at most one matches.
    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            match[k] = slot_vld[k] && (slot_val[k] == data_in);
        end
        hit_en  = (data_in != '0) && (|match);
        miss_en = (data_in != '0) && !(|match);
        hit_idx = lowest_set(match);
    end

    dvt_repl_ctrl u_repl_ctrl (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .slot_valid (slot_vld),
        .hit_en     (hit_en),
        .hit_idx    (hit_idx),
        .miss_en    (miss_en),
        .write_idx  (write_idx)
    );

    // A miss writes the chosen slot; values stay 0 until their slot is first written.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_val[k] <= '0;
            end
            slot_vld <= '0;
        end else if (miss_en) begin
            slot_val[write_idx] <= data_in;
            slot_vld[write_idx] <= 1'b1;
        end
    end

    assign out_0       = slot_val[0];
    assign out_1       = slot_val[1];
    assign out_2       = slot_val[2];
    assign out_3       = slot_val[3];
    assign out_valid_0 = slot_vld[0];
    assign out_valid_1 = slot_vld[1];
    assign out_valid_2 = slot_vld[2];
    assign out_valid_3 = slot_vld[3];

endmodule

// File: tb/tb_distinct_value_tracker.sv
// tb_distinct_value_tracker: directed and random stimulus against a set/recency
// reference model. Follows the DVT_LRU_EN macro like the design does.
module tb_distinct_value_tracker;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic [7:0] data_in;
    logic [7:0] out_0, out_1, out_2, out_3;
    logic       out_valid_0, out_valid_1, out_valid_2, out_valid_3;

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 1'b0;

    // Reference model: slot contents, eviction count for FIFO, recency list (newest first) for LRU.
    int m_val[4];
    bit m_vld[4];
    int evict_cnt;
    int lru_q[$];

    logic [7:0] dut_out[4];
    logic       dut_vld[4];

    int seq_fill[11] = '{1, 2, 3, 4, 3, 2, 3, 4, 3, 4, 0};
    int seq_alt[7]   = '{1, 2, 1, 2, 1, 2, 1};
    int seq_evict[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};

    distinct_value_tracker #(.DATA_W(8)) dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .data_in     (data_in),
        .out_0       (out_0),
        .out_1       (out_1),
        .out_2       (out_2),
        .out_3       (out_3),
        .out_valid_0 (out_valid_0),
        .out_valid_1 (out_valid_1),
        .out_valid_2 (out_valid_2),
        .out_valid_3 (out_valid_3)
    );

    assign dut_out[0] = out_0;
    assign dut_out[1] = out_1;
    assign dut_out[2] = out_2;
    assign dut_out[3] = out_3;
    assign dut_vld[0] = out_valid_0;
    assign dut_vld[1] = out_valid_1;
    assign dut_vld[2] = out_valid_2;
    assign dut_vld[3] = out_valid_3;

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_touch(input int s);
`ifdef DVT_LRU_EN
        for (int i = 0; i < lru_q.size(); i++) begin
            if (lru_q[i] == s) begin
                lru_q.delete(i);
                break;
            end
        end
        lru_q.push_front(s);
`else
        if (s < 0) $display("[TB] bad slot %0d", s);
`endif
    endtask

    task automatic model_step(input bit r, input int d);
        int hit;
        int free;
        int victim;
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                m_val[k] = 0;
                m_vld[k] = 1'b0;
            end
            evict_cnt = 0;
            lru_q = '{0, 1, 2, 3};
            return;
        end
        if (d == 0) return;
        hit  = -1;
        free = -1;
        for (int k = 0; k < 4; k++) begin
            if (m_vld[k] && m_val[k] == d) hit = k;
            if (!m_vld[k] && free < 0) free = k;
        end
        if (hit >= 0) begin
            model_touch(hit);
        end else if (free >= 0) begin
            m_val[free] = d;
            m_vld[free] = 1'b1;
            model_touch(free);
        end else begin
`ifdef DVT_LRU_EN
            victim = lru_q[3];
`else
            victim = evict_cnt % 4;
`endif
            evict_cnt++;
            m_val[victim] = d;
            model_touch(victim);
        end
    endtask

    // Drive on the falling edge, let the DUT sample at the rising edge, then advance the model.
    task automatic applyStimulus(input bit r, input int d);
        @(negedge clk_in);
        reset_in = r;
        data_in  = 8'(d);
        @(posedge clk_in);
        model_step(r, d);
    endtask

    // Pin both the DUT and the model to hand-computed slot contents.
    task automatic checkOutput(input string name, input int e0, input int e1, input int e2,
                               input int e3, input logic [3:0] ev);
        int e[4];
        e = '{e0, e1, e2, e3};
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s out_%0d", name, k), dut_out[k], e[k]);
            chk($sformatf("%s out_valid_%0d", name, k), dut_vld[k], ev[k]);
            chk($sformatf("%s model_%0d", name, k), m_val[k], e[k]);
        end
    endtask

    // Every cycle after the first reset, all outputs must track the model.
    always @(negedge clk_in) begin
        if (check_en) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("cycle out_%0d", k), dut_out[k], m_val[k]);
                chk($sformatf("cycle out_valid_%0d", k), dut_vld[k], m_vld[k]);
            end
        end
    end

    initial begin
        bit r;
        int d;
        reset_in = 1'b1;
        data_in  = '0;

        applyStimulus(1'b1, 0);
        check_en = 1'b1;
        checkOutput("reset", 0, 0, 0, 0, 4'b0000);

        for (int i = 0; i < 11; i++) applyStimulus(1'b0, seq_fill[i]);
        checkOutput("fill_repeat", 1, 2, 3, 4, 4'b1111);

        applyStimulus(1'b1, 0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, seq_alt[i]);
        checkOutput("alternate", 1, 2, 0, 0, 4'b0011);

        applyStimulus(1'b1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, seq_evict[i]);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b0, 5);
`ifdef DVT_LRU_EN
        checkOutput("hit_then_evict", 1, 5, 3, 4, 4'b1111);
`else
        checkOutput("hit_then_evict", 5, 2, 3, 4, 4'b1111);
`endif

        applyStimulus(1'b1, 0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, seq_evict[i]);
        checkOutput("evict_wrap", 9, 6, 7, 8, 4'b1111);

        applyStimulus(1'b1, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 0);
        checkOutput("idle", 0, 0, 0, 0, 4'b0000);

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, i + 1);
        applyStimulus(1'b1, 7);
        checkOutput("reset_mid", 0, 0, 0, 0, 4'b0000);
        applyStimulus(1'b0, 7);
        checkOutput("after_reset", 7, 0, 0, 0, 4'b0001);

        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 49) == 0);
            d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 9));
            applyStimulus(r, d);
        end

        @(negedge clk_in);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
